// File: rtl/minitb_ahb_slave.sv
// minitb_ahb_slave: word-addressed AHB-style memory slave with a programmable
// number of wait states and pipelined (back-to-back) transfer support.
// Optional feature macro: MINITB_AHB_SLAVE_ERR_EN -- when defined, an accepted
// transfer addressing haddr >= memDepth gets a two-cycle ERROR response;
// when undefined, hresp is always OKAY and the address wraps modulo memDepth.
module minitb_ahb_slave #(
    parameter int addrWidth  = 8,
    parameter int dataWidth  = 32,
    parameter int memDepth   = 256,
    parameter int waitStates = 0
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 hsel,
    input  logic [1:0]           htrans,
    input  logic [addrWidth-1:0] haddr,
    input  logic                 hwrite,
    input  logic [dataWidth-1:0] hwdata,
    input  logic                 hready,
    output logic                 hreadyout,
    output logic [1:0]           hresp,
    output logic [dataWidth-1:0] hrdata
);

`ifdef MINITB_AHB_SLAVE_ERR_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
`endif

    localparam int         IDX_W     = (memDepth > 1) ? $clog2(memDepth) : 1;
    // The counter is loaded with waitStates-1 so S_WAIT lasts exactly waitStates cycles.
    localparam logic [3:0] WAIT_LOAD = (waitStates > 0) ? 4'(waitStates - 1) : 4'd0;

    // Storage index: the word address folded into the memory depth.
    function automatic logic [IDX_W-1:0] mem_idx(input logic [addrWidth-1:0] a);
        return IDX_W'(32'(a) % memDepth);
    endfunction

`ifdef MINITB_AHB_SLAVE_ERR_EN
    function automatic logic addr_err(input logic [addrWidth-1:0] a);
        return 32'(a) >= memDepth;
    endfunction
`endif

    logic [dataWidth-1:0] mem [memDepth];

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 write_q, write_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 hreadyout_q, hreadyout_d;
    logic [1:0]           hresp_q, hresp_d;
    logic [dataWidth-1:0] hrdata_q, hrdata_d;

    logic accept;
    logic commit;
    logic unused_htrans0;

    // Only htrans[1] matters: NONSEQ and SEQ are both real transfers.
    assign unused_htrans0 = htrans[0];
    assign accept = hsel && htrans[1] && hready;
    // A write lands on the edge that ends its S_DONE data phase.
    assign commit = (state_q == S_DONE) && write_q;

    // Next-state and next-output logic; outputs are derived from the next state.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        hreadyout_d = 1'b1;
        hresp_d     = 2'b00;
        hrdata_d    = '0;

        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef MINITB_AHB_SLAVE_ERR_EN
            S_ERR1: state_d = S_ERR2;
            // The bus sees hready=1 here, but the slave deliberately ignores the new transfer.
            S_ERR2: state_d = S_IDLE;
`endif
            default: begin
                // S_IDLE and S_DONE both accept; from S_DONE this is the pipelined case.
                state_d = S_IDLE;
                if (accept) begin
                    idx_d   = mem_idx(haddr);
                    write_d = hwrite;
                    state_d = (waitStates > 0) ? S_WAIT : S_DONE;
                    cnt_d   = WAIT_LOAD;
`ifdef MINITB_AHB_SLAVE_ERR_EN
                    if (addr_err(haddr)) begin
                        state_d = S_ERR1;
                        cnt_d   = 4'd0;
                    end
`endif
                end
            end
        endcase

        case (state_d)
            S_WAIT: hreadyout_d = 1'b0;
            S_DONE: begin
                if (!write_d) begin
                    // Forward write data completing on this same edge to the same word.
                    hrdata_d = (commit && (idx_q == idx_d)) ? hwdata : mem[idx_d];
                end
            end
`ifdef MINITB_AHB_SLAVE_ERR_EN
            S_ERR1: begin
                hreadyout_d = 1'b0;
                hresp_d     = 2'b01;
            end
            S_ERR2: hresp_d = 2'b01;
`endif
            default: ;
        endcase
    end

    // Control state and registered bus outputs, cleared asynchronously by hresetn.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            write_q     <= 1'b0;
            cnt_q       <= 4'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 2'b00;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
        end
    end

    // Storage write port; not reset, and a reset-aborted data phase never reaches S_DONE.
    always_ff @(posedge hclk) begin
        if (commit) begin
            mem[idx_q] <= hwdata;
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
    assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_minitb_ahb_slave.sv
// tb_minitb_ahb_slave: three slave instances (different wait states / depths)
// driven by a pipelined bus master and checked against an ordered memory model.
module tb_minitb_ahb_slave;

    localparam int ND      = 3;
    localparam int K_XFER  = 0;
    localparam int K_BUSY  = 1;
    localparam int K_NOSEL = 2;
    localparam int K_IDLE  = 3;

    logic        clk = 1'b0;
    logic        hresetn   [ND];
    logic        hsel      [ND];
    logic [1:0]  htrans    [ND];
    logic [7:0]  haddr     [ND];
    logic        hwrite    [ND];
    logic [31:0] hwdata    [ND];
    logic        hreadyout [ND];
    logic [1:0]  hresp     [ND];
    logic [31:0] hrdata    [ND];

    int vectors     = 0;
    int miscompares = 0;

    // Reference memory: value and "has been written" flag per storage word.
    logic [31:0] mem_m [ND][256];
    bit          wr_m  [ND][256];

    // Transfer list consumed by run_seq.
    int          seq_kind [64];
    logic        seq_wr   [64];
    logic [7:0]  seq_addr [64];
    logic [31:0] seq_data [64];
    int          seq_n;

    always #5 clk = ~clk;

    minitb_ahb_slave #(.addrWidth(8), .dataWidth(32), .memDepth(256), .waitStates(0)) u0 (
        .hclk(clk), .hresetn(hresetn[0]), .hsel(hsel[0]), .htrans(htrans[0]),
        .haddr(haddr[0]), .hwrite(hwrite[0]), .hwdata(hwdata[0]), .hready(hreadyout[0]),
        .hreadyout(hreadyout[0]), .hresp(hresp[0]), .hrdata(hrdata[0]));

    minitb_ahb_slave #(.addrWidth(8), .dataWidth(32), .memDepth(256), .waitStates(2)) u1 (
        .hclk(clk), .hresetn(hresetn[1]), .hsel(hsel[1]), .htrans(htrans[1]),
        .haddr(haddr[1]), .hwrite(hwrite[1]), .hwdata(hwdata[1]), .hready(hreadyout[1]),
        .hreadyout(hreadyout[1]), .hresp(hresp[1]), .hrdata(hrdata[1]));

    minitb_ahb_slave #(.addrWidth(8), .dataWidth(32), .memDepth(16), .waitStates(1)) u2 (
        .hclk(clk), .hresetn(hresetn[2]), .hsel(hsel[2]), .htrans(htrans[2]),
        .haddr(haddr[2]), .hwrite(hwrite[2]), .hwdata(hwdata[2]), .hready(hreadyout[2]),
        .hreadyout(hreadyout[2]), .hresp(hresp[2]), .hrdata(hrdata[2]));

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int depth_of(input int d);
        return (d == 2) ? 16 : 256;
    endfunction

    function automatic bit expect_err(input int d, input logic [7:0] a);
        bit e;
        e = int'(a) >= depth_of(d);
`ifndef MINITB_AHB_SLAVE_ERR_EN
        e = 1'b0;
`endif
        return e;
    endfunction

    task automatic seq_clear();
        seq_n = 0;
    endtask

    task automatic add_xfer(input logic wr, input logic [7:0] a, input logic [31:0] dat);
        seq_kind[seq_n] = K_XFER;
        seq_wr[seq_n]   = wr;
        seq_addr[seq_n] = a;
        seq_data[seq_n] = dat;
        seq_n++;
    endtask

    task automatic add_ign(input int kind, input logic [7:0] a);
        seq_kind[seq_n] = kind;
        seq_wr[seq_n]   = 1'b1;
        seq_addr[seq_n] = a;
        seq_data[seq_n] = $urandom;
        seq_n++;
    endtask

    // Present address-phase signals of list entry i (or an idle bus when i < 0).
    task automatic drive_addr(input int d, input int i);
        if (i < 0) begin
            hsel[d]   = 1'b0;
            htrans[d] = 2'b00;
            haddr[d]  = 8'($urandom);
            hwrite[d] = 1'($urandom);
        end else begin
            haddr[d]  = seq_addr[i];
            hwrite[d] = seq_wr[i];
            case (seq_kind[i])
                K_XFER:  begin hsel[d] = 1'b1; htrans[d] = {1'b1, 1'($urandom)}; end
                K_BUSY:  begin hsel[d] = 1'b1; htrans[d] = 2'b01; end
                K_NOSEL: begin hsel[d] = 1'b0; htrans[d] = 2'b10; end
                default: begin hsel[d] = 1'b1; htrans[d] = 2'b00; end
            endcase
        end
    endtask

    // Pipelined master: runs the transfer list on DUT d. Must be entered just after a rising edge.
    task automatic run_seq(input int d);
        int          ap, dp, nxt, waits, cycles, ix, exp_w;
        bit          err, done_now, hold;
        logic        rdy;
        logic [1:0]  resp, exp_resp;
        logic [31:0] rd, exp_rd;
        ap = 0; dp = -1; waits = 0; cycles = 0; hold = 1'b0;
        hwdata[d] = $urandom;
        drive_addr(d, (seq_n > 0) ? 0 : -1);
        while ((ap < seq_n || dp >= 0) && cycles < 400) begin
            @(negedge clk);
            cycles++;
            rdy = hreadyout[d]; resp = hresp[d]; rd = hrdata[d];
            done_now = 1'b0;
            if (dp < 0) begin
                vectors++;
                if (rdy !== 1'b1 || resp !== 2'b00 || rd !== 32'h0) begin
                    miscompares++;
                    $display("FAIL idle_outputs dut%0d: got ready=%b resp=%b rdata=%h, want 1/00/0",
                             d, rdy, resp, rd);
                end
            end else begin
                err      = expect_err(d, seq_addr[dp]);
                exp_resp = err ? 2'b01 : 2'b00;
                if (rdy !== 1'b1) begin
                    waits++;
                    vectors++;
                    if (resp !== exp_resp || rd !== 32'h0) begin
                        miscompares++;
                        $display("FAIL wait_phase dut%0d addr=%h: got resp=%b rdata=%h, want %b/0",
                                 d, seq_addr[dp], resp, rd, exp_resp);
                    end
                end else begin
                    done_now = 1'b1;
                    ix    = int'(seq_addr[dp]) % depth_of(d);
                    exp_w = err ? 1 : ws_of(d);
                    vectors++;
                    if (waits != exp_w) begin
                        miscompares++;
                        $display("FAIL wait_count dut%0d addr=%h: got %0d low cycles, want %0d",
                                 d, seq_addr[dp], waits, exp_w);
                    end
                    vectors++;
                    if (resp !== exp_resp) begin
                        miscompares++;
                        $display("FAIL hresp dut%0d addr=%h: got %b, want %b", d, seq_addr[dp], resp, exp_resp);
                    end
                    if (seq_wr[dp] || err || wr_m[d][ix]) begin
                        exp_rd = (seq_wr[dp] || err) ? 32'h0 : mem_m[d][ix];
                        vectors++;
                        if (rd !== exp_rd) begin
                            miscompares++;
                            $display("FAIL hrdata dut%0d %s addr=%h: got %h, want %h",
                                     d, seq_wr[dp] ? "wr" : "rd", seq_addr[dp], rd, exp_rd);
                        end
                    end
                    if (seq_wr[dp] && !err) begin
                        mem_m[d][ix] = seq_data[dp];
                        wr_m[d][ix]  = 1'b1;
                    end
                end
            end
            nxt = done_now ? -1 : dp;
            if (rdy === 1'b1 && !hold && ap < seq_n) begin
                if (seq_kind[ap] == K_XFER) nxt = ap;
                ap++;
            end
            @(posedge clk);
            #1;
            if (nxt != dp) waits = 0;
            dp = nxt;
            hwdata[d] = (dp >= 0 && seq_wr[dp]) ? seq_data[dp] : $urandom;
            // After an ERROR-bound transfer the master idles until the response finishes.
            hold = (dp >= 0) && expect_err(d, seq_addr[dp]);
            drive_addr(d, (!hold && ap < seq_n) ? ap : -1);
        end
        if (ap < seq_n || dp >= 0) begin
            vectors++;
            miscompares++;
            $display("FAIL seq_timeout dut%0d: %0d of %0d entries issued, data phase %0d pending",
                     d, ap, seq_n, dp);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < ND; d++) begin
            hresetn[d] = 1'b0;
            drive_addr(d, -1);
            hwdata[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            vectors++;
            if (hreadyout[d] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_ready dut%0d: got %b, want 1", d, hreadyout[d]);
            end
            vectors++;
            if (hresp[d] !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_resp dut%0d: got %b, want 00", d, hresp[d]);
            end
            vectors++;
            if (hrdata[d] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_rdata dut%0d: got %h, want 0", d, hrdata[d]);
            end
        end
        // Release just after an edge so the very next edge must accept a transfer.
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) hresetn[d] = 1'b1;
    endtask

    task automatic test_basic();
        seq_clear();
        add_xfer(1'b1, 8'h10, 32'hDEADBEEF);
        add_xfer(1'b0, 8'h10, 32'h0);
        run_seq(0);
    endtask

    task automatic test_wait_states();
        seq_clear();
        add_xfer(1'b1, 8'h05, 32'hA5A5A5A5);
        add_xfer(1'b0, 8'h05, 32'h0);
        run_seq(1);
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 2; d++) begin
            seq_clear();
            add_xfer(1'b1, 8'h20, 32'h1);
            add_xfer(1'b0, 8'h20, 32'h0);
            add_xfer(1'b1, 8'h20, 32'h0BADF00D);
            add_xfer(1'b0, 8'h20, 32'h0);
            add_xfer(1'b1, 8'h21, 32'h2);
            add_xfer(1'b0, 8'h20, 32'h0);
            run_seq(d);
        end
    endtask

    task automatic test_ignored();
        for (int d = 0; d < 2; d++) begin
            seq_clear();
            add_xfer(1'b1, 8'h40, 32'hCAFEF00D);
            add_ign(K_NOSEL, 8'h40);
            add_ign(K_BUSY, 8'h40);
            add_ign(K_IDLE, 8'h40);
            add_ign(K_NOSEL, 8'h40);
            add_xfer(1'b0, 8'h40, 32'h0);
            run_seq(d);
        end
    endtask

    task automatic test_wrap_err();
        seq_clear();
        add_xfer(1'b1, 8'h00, 32'h12345678);
        add_xfer(1'b1, 8'h20, 32'h00000055);
        add_xfer(1'b0, 8'h00, 32'h0);
        add_xfer(1'b0, 8'h20, 32'h0);
        add_xfer(1'b1, 8'h13, 32'h77770013);
        add_xfer(1'b0, 8'h03, 32'h0);
        run_seq(2);
    endtask

    task automatic test_reset_mid_write();
        seq_clear();
        add_xfer(1'b1, 8'h30, 32'h11111111);
        run_seq(1);
        hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 8'h30; hwrite[1] = 1'b1;
        @(posedge clk);
        #1;
        drive_addr(1, -1);
        hwdata[1] = 32'h00000077;
        @(negedge clk);
        vectors++;
        if (hreadyout[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL midwrite_in_wait: got ready=%b, want 0", hreadyout[1]);
        end
        #1;
        hresetn[1] = 1'b0;
        #1;
        vectors++;
        if (hreadyout[1] !== 1'b1 || hresp[1] !== 2'b00 || hrdata[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: got ready=%b resp=%b rdata=%h, want 1/00/0",
                     hreadyout[1], hresp[1], hrdata[1]);
        end
        repeat (2) @(posedge clk);
        #1;
        hresetn[1] = 1'b1;
        seq_clear();
        add_xfer(1'b0, 8'h30, 32'h0);
        run_seq(1);
    endtask

    task automatic test_random();
        logic [7:0] last_a;
        int         r;
        for (int d = 0; d < ND; d++) begin
            seq_clear();
            last_a = 8'h00;
            for (int i = 0; i < 40; i++) begin
                r = $urandom_range(0, 9);
                if (r < 4) begin
                    last_a = 8'($urandom_range(0, 63));
                    add_xfer(1'b1, last_a, $urandom);
                end else if (r < 8) begin
                    add_xfer(1'b0, (r < 6) ? last_a : 8'($urandom_range(0, 63)), 32'h0);
                end else begin
                    add_ign($urandom_range(1, 3), 8'($urandom_range(0, 63)));
                end
            end
            run_seq(d);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_back_to_back();
        test_ignored();
        test_wrap_err();
        test_reset_mid_write();
        test_random();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
